// File: rtl/cpu_mc_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mc_pkg
// Shared definitions for the multicycle 4-register core: instruction byte
// layout, opcode values, FSM state encoding and a couple of decode helpers.
// No ports; imported by cpu_core_mc and regfile_n.
// ---------------------------------------------------------------------------
package cpu_mc_pkg;

    // Every instruction byte (first or second) is one memory word wide
    localparam int INSTR_W = 8;

    // Field positions inside the first instruction byte
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int SUB_BIT = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 2;
    localparam int RS_MSB  = 1;
    localparam int RS_LSB  = 0;

    // Opcodes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;   // sub=1 turns this into HALT

    // FSM state encoding
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_FETCH2 = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_HALT   = 3'd4;

    // ALU operations occupy the low five opcodes
    function automatic logic isAluOp(input logic [2:0] opc);
        return (opc <= OP_XOR);
    endfunction

    // LDI, JZ and JMP carry a second byte
    function automatic logic isTwoByte(input logic [2:0] opc);
        return (opc >= OP_LDI);
    endfunction

endpackage

// File: rtl/regfile_n.sv
// ---------------------------------------------------------------------------
// regfile_n
// Four-entry register file, DATA_W bits per entry. One synchronous write
// port, two asynchronous read ports, synchronous clear on reset.
// Ports:
//   clk, reset          clock / synchronous active-high reset
//   i_we, i_waddr,
//   i_wdata             write port
//   i_raddrA, o_rdataA  read port A (combinational)
//   i_raddrB, o_rdataB  read port B (combinational)
// ---------------------------------------------------------------------------
module regfile_n
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [1:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_raddrA,
    output logic [DATA_W-1:0] o_rdataA,
    input  logic [1:0]        i_raddrB,
    output logic [DATA_W-1:0] o_rdataB
);

    logic [DATA_W-1:0] r_regs [4];

    // Storage: cleared together on reset, otherwise one write per cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Reads are asynchronous so EXEC sees the value written by any
    // earlier instruction without an extra cycle
    assign o_rdataA = r_regs[i_raddrA];
    assign o_rdataB = r_regs[i_raddrB];

endmodule

// File: rtl/cpu_core_mc.sv
// ---------------------------------------------------------------------------
// cpu_core_mc
// Multicycle 4-register core: FETCH -> DECODE -> (FETCH2) -> EXEC with a
// one-byte ALU format, two-byte LDI/JZ/JMP, zero flag and absorbing HALT.
// Ports:
//   clk, reset      clock / synchronous active-high reset
//   stall           freezes all architectural state while high
//   imem_addr       instruction address (equals pc)
//   imem_rdata      instruction byte at imem_addr, same cycle
//   pc              program counter
//   zero            zero flag of the last ALU result
//   halted          high while in HALT
//   dbg_we/_waddr/_wdata  registered trace of each register write
// ---------------------------------------------------------------------------
module cpu_core_mc
    import cpu_mc_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  pc,
    output logic               zero,
    output logic               halted,
    output logic               dbg_we,
    output logic [1:0]         dbg_waddr,
    output logic [DATA_W-1:0]  dbg_wdata
);

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [INSTR_W-1:0] r_operand;
    logic               r_zero;
    logic               r_dbgWe;
    logic [1:0]         r_dbgWaddr;
    logic [DATA_W-1:0]  r_dbgWdata;

    logic [2:0]         w_opc;
    logic               w_sub;
    logic [1:0]         w_rd;
    logic [1:0]         w_rs;
    logic [DATA_W-1:0]  w_rdVal;
    logic [DATA_W-1:0]  w_rsVal;
    logic [DATA_W-1:0]  w_aluRes;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_isWrite;
    logic               w_regWe;
    logic [ADDR_W-1:0]  w_pcNext;

    assign w_opc = r_ir[OPC_MSB:OPC_LSB];
    assign w_sub = r_ir[SUB_BIT];
    assign w_rd  = r_ir[RD_MSB:RD_LSB];
    assign w_rs  = r_ir[RS_MSB:RS_LSB];

    // Natural ADDR_W-bit wrap covers the second-byte fetch at the top too
    assign w_pcNext = r_pc + ADDR_W'(1);

    regfile_n #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .i_we     (w_regWe),
        .i_waddr  (w_rd),
        .i_wdata  (w_wdata),
        .i_raddrA (w_rd),
        .o_rdataA (w_rdVal),
        .i_raddrB (w_rs),
        .o_rdataB (w_rsVal)
    );

    // ALU: results are naturally truncated to DATA_W bits
    always_comb begin
        w_aluRes = '0;
        case (w_opc)
            OP_ADD:  w_aluRes = w_rdVal + w_rsVal;
            OP_SUB:  w_aluRes = w_rdVal - w_rsVal;
            OP_AND:  w_aluRes = w_rdVal & w_rsVal;
            OP_OR:   w_aluRes = w_rdVal | w_rsVal;
            OP_XOR:  w_aluRes = w_rdVal ^ w_rsVal;
            default: w_aluRes = '0;
        endcase
    end

    // Register write happens only on a non-stalled EXEC of an ALU op or LDI
    assign w_isWrite = isAluOp(w_opc) || (w_opc == OP_LDI);
    assign w_regWe   = (r_state == ST_EXEC) && !stall && !reset && w_isWrite;
    assign w_wdata   = (w_opc == OP_LDI) ? r_operand[DATA_W-1:0] : w_aluRes;

    // Main FSM; the trace pulse is cleared every non-reset cycle so a
    // stalled EXEC never produces or stretches it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_FETCH;
            r_pc       <= '0;
            r_ir       <= '0;
            r_operand  <= '0;
            r_zero     <= 1'b0;
            r_dbgWe    <= 1'b0;
            r_dbgWaddr <= '0;
            r_dbgWdata <= '0;
        end else begin
            r_dbgWe <= 1'b0;
            if (!stall) begin
                case (r_state)
                    ST_FETCH: begin
                        r_ir    <= imem_rdata;
                        r_pc    <= w_pcNext;
                        r_state <= ST_DECODE;
                    end
                    ST_DECODE: begin
                        if ((w_opc == OP_JMP) && w_sub) begin
                            r_state <= ST_HALT;
                        end else if (isTwoByte(w_opc)) begin
                            r_state <= ST_FETCH2;
                        end else begin
                            r_state <= ST_EXEC;
                        end
                    end
                    ST_FETCH2: begin
                        r_operand <= imem_rdata;
                        r_pc      <= w_pcNext;
                        r_state   <= ST_EXEC;
                    end
                    ST_EXEC: begin
                        if (w_isWrite) begin
                            r_dbgWe    <= 1'b1;
                            r_dbgWaddr <= w_rd;
                            r_dbgWdata <= w_wdata;
                        end
                        if (isAluOp(w_opc)) begin
                            r_zero <= (w_aluRes == '0);
                        end
                        if ((w_opc == OP_JMP) || ((w_opc == OP_JZ) && r_zero)) begin
                            r_pc <= r_operand[ADDR_W-1:0];
                        end
                        r_state <= ST_FETCH;
                    end
                    ST_HALT: begin
                        r_state <= ST_HALT;
                    end
                    default: begin
                        r_state <= ST_FETCH;
                    end
                endcase
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign zero      = r_zero;
    assign halted    = (r_state == ST_HALT);
    assign dbg_we    = r_dbgWe;
    assign dbg_waddr = r_dbgWaddr;
    assign dbg_wdata = r_dbgWdata;

endmodule

// File: tb/tb_cpu_core_mc.sv
// ---------------------------------------------------------------------------
// tb_cpu_core_mc
// Directed programs for cpu_core_mc. Expected register writes go into a
// queue; a monitor pops one entry per dbg_we pulse. pc/zero/halted and
// cycle counts are compared directly against hand-computed values.
// A second instance with ADDR_W=4 covers the pc wrap case.
// ---------------------------------------------------------------------------
module tb_cpu_core_mc;

    typedef struct {
        logic [1:0] addr;
        logic [3:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic [7:0] imemAddr;
    logic [7:0] imemRdata;
    logic [7:0] pc;
    logic       zero;
    logic       halted;
    logic       dbgWe;
    logic [1:0] dbgWaddr;
    logic [3:0] dbgWdata;

    logic       reset4 = 1'b1;
    logic       stall4 = 1'b0;
    logic [3:0] imemAddr4;
    logic [7:0] imemRdata4;
    logic [3:0] pc4;
    logic       zero4;
    logic       halted4;
    logic       dbgWe4;
    logic [1:0] dbgWaddr4;
    logic [3:0] dbgWdata4;

    logic [7:0] mem  [256];
    logic [7:0] mem4 [16];

    wr_t expQ [$];
    int  nChecks = 0;
    int  nFails  = 0;
    int  edges;

    always #5 clk = ~clk;

    assign imemRdata  = mem[imemAddr];
    assign imemRdata4 = mem4[imemAddr4];

    cpu_core_mc #(.DATA_W(4), .ADDR_W(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .imem_addr  (imemAddr),
        .imem_rdata (imemRdata),
        .pc         (pc),
        .zero       (zero),
        .halted     (halted),
        .dbg_we     (dbgWe),
        .dbg_waddr  (dbgWaddr),
        .dbg_wdata  (dbgWdata)
    );

    cpu_core_mc #(.DATA_W(4), .ADDR_W(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset4),
        .stall      (stall4),
        .imem_addr  (imemAddr4),
        .imem_rdata (imemRdata4),
        .pc         (pc4),
        .zero       (zero4),
        .halted     (halted4),
        .dbg_we     (dbgWe4),
        .dbg_waddr  (dbgWaddr4),
        .dbg_wdata  (dbgWdata4)
    );

    // Compare one value and report it
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [1:0] a, input logic [3:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        expQ.push_back(e);
    endtask

    // Fill memory with HALT so a runaway program stops quickly
    task automatic clearMem();
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        for (int i = 0; i < 16; i++)  mem4[i] = 8'hF0;
    endtask

    // Hold reset two cycles, check reset values, then release
    task automatic applyStimulus(input string tag);
        reset = 1'b1;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput({tag, "_rst_pc"}, 32'(pc), 0);
        checkOutput({tag, "_rst_halted"}, 32'(halted), 0);
        checkOutput({tag, "_rst_dbgwe"}, 32'(dbgWe), 0);
        reset = 1'b0;
    endtask

    // Wait for halted with a cycle budget; returns edges consumed
    task automatic waitHalted(input string tag, input int budget, output int n);
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (halted !== 1'b1) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s_timeout: halted=%0b after %0d cycles, expected 1", tag, halted, n);
        end
    endtask

    task automatic checkDrained(input string tag);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_queue_left"}, 32'(expQ.size()), 0);
    endtask

    // Scoreboard monitor for the main instance
    always @(negedge clk) begin
        if (dbgWe === 1'b1) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=%0d, expected no write",
                         dbgWaddr, dbgWdata);
            end else begin
                wr_t e;
                e = expQ.pop_front();
                checkOutput("dbg_waddr", 32'(dbgWaddr), 32'(e.addr));
                checkOutput("dbg_wdata", 32'(dbgWdata), 32'(e.data));
            end
        end
        if (dbgWe4 === 1'b1) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL dut4_write: got addr=%0d data=%0d, expected no write",
                     dbgWaddr4, dbgWdata4);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int total;

        // LDI R0,3; LDI R1,5; ADD R0,R1; HALT
        clearMem();
        mem[0] = 8'hA0; mem[1] = 8'h03; mem[2] = 8'hA4; mem[3] = 8'h05;
        mem[4] = 8'h01; mem[5] = 8'hF0;
        applyStimulus("t1");
        expectWrite(0, 3); expectWrite(1, 5); expectWrite(0, 8);
        waitHalted("t1", 40, edges);
        checkOutput("t1_halt_cycles", 32'(edges), 13);
        checkDrained("t1");
        checkOutput("t1_pc_frozen", 32'(pc), 6);
        checkOutput("t1_halted_held", 32'(halted), 1);

        // 15+1 wraps to 0, zero set, JZ taken to 0x20
        clearMem();
        mem[0] = 8'hA8; mem[1] = 8'h0F; mem[2] = 8'hAC; mem[3] = 8'h01;
        mem[4] = 8'h0B; mem[5] = 8'hC0; mem[6] = 8'h20;
        applyStimulus("t2");
        expectWrite(2, 15); expectWrite(3, 1); expectWrite(2, 0);
        repeat (11) @(negedge clk);
        checkOutput("t2_zero_after_add", 32'(zero), 1);
        waitHalted("t2", 40, edges);
        checkDrained("t2");
        checkOutput("t2_pc_jz_taken", 32'(pc), 8'h21);

        // SUB R0,R0 -> zero; ADD nonzero -> zero clear; JZ falls through
        clearMem();
        mem[0] = 8'hA0; mem[1] = 8'h07; mem[2] = 8'h20; mem[3] = 8'hA4;
        mem[4] = 8'h02; mem[5] = 8'h01; mem[6] = 8'hC0; mem[7] = 8'h30;
        applyStimulus("t3");
        expectWrite(0, 7); expectWrite(0, 0); expectWrite(1, 2); expectWrite(0, 2);
        repeat (7) @(negedge clk);
        checkOutput("t3_zero_after_sub", 32'(zero), 1);
        waitHalted("t3", 40, edges);
        checkOutput("t3_halt_cycles", 32'(edges), 13);
        checkDrained("t3");
        checkOutput("t3_zero_cleared", 32'(zero), 0);
        checkOutput("t3_pc_fallthrough", 32'(pc), 9);

        // Stall five cycles while in FETCH2 of the first LDI
        clearMem();
        mem[0] = 8'hA0; mem[1] = 8'h03; mem[2] = 8'hA4; mem[3] = 8'h05;
        mem[4] = 8'h01; mem[5] = 8'hF0;
        applyStimulus("t5");
        expectWrite(0, 3); expectWrite(1, 5); expectWrite(0, 8);
        repeat (2) @(negedge clk);
        stall = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t5_pc_held", 32'(pc), 1);
        stall = 1'b0;
        waitHalted("t5", 40, edges);
        total = 7 + edges;
        checkOutput("t5_halt_cycles", 32'(total), 18);
        checkDrained("t5");
        checkOutput("t5_pc_final", 32'(pc), 6);

        // Reset lands on the EXEC edge of ADD
        applyStimulus("t6");
        expectWrite(0, 3); expectWrite(1, 5);
        repeat (10) @(negedge clk);
        checkOutput("t6_pc_before_rst", 32'(pc), 5);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t6_rst_pc", 32'(pc), 0);
        checkOutput("t6_rst_zero", 32'(zero), 0);
        checkOutput("t6_rst_halted", 32'(halted), 0);
        checkOutput("t6_rst_dbgwe", 32'(dbgWe), 0);
        checkOutput("t6_rst_dbgwaddr", 32'(dbgWaddr), 0);
        checkOutput("t6_rst_dbgwdata", 32'(dbgWdata), 0);
        checkOutput("t6_queue_at_rst", 32'(expQ.size()), 0);
        reset = 1'b0;
        expectWrite(0, 3); expectWrite(1, 5); expectWrite(0, 8);
        waitHalted("t6", 40, edges);
        checkOutput("t6_restart_cycles", 32'(edges), 13);
        checkDrained("t6");

        // ADDR_W=4: JMP 14, then JMP whose operand sits at 15, pc wraps
        reset = 1'b1;
        clearMem();
        mem4[0] = 8'hE0; mem4[1] = 8'h0E; mem4[14] = 8'hE0; mem4[15] = 8'h13;
        reset4 = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("t4_rst_pc", 32'(pc4), 0);
        reset4 = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("t4_pc_jmp14", 32'(pc4), 14);
        repeat (3) @(negedge clk);
        checkOutput("t4_pc_wrap", 32'(pc4), 0);
        repeat (1) @(negedge clk);
        checkOutput("t4_pc_jmp13", 32'(pc4), 3);
        repeat (2) @(negedge clk);
        checkOutput("t4_halted", 32'(halted4), 1);
        checkOutput("t4_pc_final", 32'(pc4), 4);
        checkOutput("t4_zero", 32'(zero4), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
